// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared UART transmitter encodings and baud helper
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int unsigned baud_max(input int unsigned clk, input int unsigned bps);
        return clk / bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock show-ahead FIFO with registered full/empty flags
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             w_do_wr;
    logic             w_do_rd;

    // A write is judged against the full flag held at the start of the cycle.
    assign w_do_wr = i_wr_en & ~full_q;
    assign w_do_rd = i_rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, w_do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, w_do_rd};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[rd_ptr_q[AW-1:0]];
    assign o_full    = full_q;
    assign o_empty   = empty_q;

endmodule
`default_nettype wire

// File: rtl/uart_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_frame_tx : FIFO-buffered 8N1 UART transmitter with per-frame done pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned UART_BPS    = 9600,
    parameter int          FIFO_DEPTH  = 16,
    parameter int unsigned FRAME_BYTES = 10000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       fifo_full,
    output logic       busy,
    output logic       overflow,
    output logic       frame_done
);

    localparam int unsigned BAUD_CNT_MAX = baud_max(CLK_FREQ, UART_BPS);
    localparam int BW = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int FW = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES) : 1;

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [FW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        tx_q, tx_d;
    logic        overflow_q, overflow_d;
    logic        frame_done_q, frame_done_d;

    logic        w_pop;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic [7:0]  w_fifo_data;
    logic        w_baud_wrap;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .i_wr_en   (pi_flag),
        .i_wr_data (pi_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_baud_wrap = (baud_cnt_q == BW'(BAUD_CNT_MAX - 1));

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        sh_d         = sh_q;
        frame_done_d = 1'b0;
        w_pop        = 1'b0;
        overflow_d   = overflow_q | (pi_flag & w_fifo_full);

        if (state_q == ST_IDLE) begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (!w_fifo_empty) begin
                w_pop   = 1'b1;
                sh_d    = w_fifo_data;
                state_d = ST_START;
            end
        end else begin
            baud_cnt_d = w_baud_wrap ? '0 : baud_cnt_q + BW'(1);
        end

        case (state_q)
            ST_START: begin
                if (w_baud_wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_wrap) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_wrap) begin
                    state_d = ST_IDLE;
                    if (byte_cnt_q == FW'(FRAME_BYTES - 1)) begin
                        byte_cnt_d   = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + FW'(1);
                    end
                end
            end
            default: ;
        endcase

        // The line level is registered from the next state so tx tracks state_q.
        case (state_d)
            ST_START: tx_d = START_BIT;
            ST_DATA:  tx_d = sh_d[bit_cnt_d];
            default:  tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            sh_q         <= '0;
            tx_q         <= STOP_BIT;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            sh_q         <= sh_d;
            tx_q         <= tx_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign fifo_full  = w_fifo_full;
    assign busy       = (state_q != ST_IDLE) | ~w_fifo_empty;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_frame_tx : randomized scoreboard bench with a timing-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;

    localparam int BIT_CLKS = 52;
    localparam int BYTE_GAP = 10 * BIT_CLKS + 1;
    localparam int DEPTH    = 16;
    localparam int FRAME    = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic       tx, fifo_full, busy, overflow, frame_done;

    int total = 0;
    int bad   = 0;

    uart_frame_tx #(
        .CLK_FREQ    (500_000),
        .UART_BPS    (9600),
        .FIFO_DEPTH  (DEPTH),
        .FRAME_BYTES (FRAME)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pi_data    (pi_data),
        .pi_flag    (pi_flag),
        .tx         (tx),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference model: a buffer of accepted bytes and a transmitter that can
    // take one byte every BYTE_GAP clocks, starting the cycle after it is free.
    logic [7:0] exp_q[$];
    int  m_occ = 0;
    longint pcyc = 0;
    longint m_free = 0;
    bit  m_ovf = 0;

    always @(posedge sys_clk) begin
        bit m_full, m_pop;
        if (!sys_rst_n) begin
            m_occ  = 0;
            m_free = 0;
            m_ovf  = 0;
            exp_q.delete();
        end else begin
            m_full = (m_occ == DEPTH);
            m_pop  = (m_occ > 0) && (pcyc >= m_free);
            if (pi_flag) begin
                if (m_full) m_ovf = 1;
                else begin
                    exp_q.push_back(pi_data);
                    m_occ++;
                end
            end
            if (m_pop) begin
                m_occ--;
                m_free = pcyc + BYTE_GAP;
            end
        end
        pcyc++;
    end

    // Monitor: decodes the serial line at mid-bit and checks against the scoreboard.
    longint ncyc = 0;
    bit  mon_active = 0;
    int  mon_cnt = 0;
    logic [7:0] mon_byte;
    longint last_stop = -1000;
    longint start_cyc = 0, prev_start = 0;
    bit  have_prev = 0;
    bit  gap_en = 0;
    int  bytes_since_rst = 0;
    int  dec_count = 0;
    int  fd_count = 0;
    bit  fd_prev = 0;
    int  ff_bad = 0;
    bit  seen_full = 0;

    always @(negedge sys_clk) begin
        int idx;
        ncyc++;
        if (!sys_rst_n) begin
            mon_active      = 0;
            bytes_since_rst = 0;
            fd_prev         = 0;
        end else begin
            if (frame_done) begin
                check("frame_done_pos", int'(bytes_since_rst > 0 && bytes_since_rst % FRAME == 0
                      && ncyc == last_stop + 26 && !fd_prev), 1);
                fd_count++;
            end
            fd_prev = frame_done;
            if (fifo_full !== (m_occ == DEPTH)) ff_bad++;
            if (fifo_full) seen_full = 1;
            if (!mon_active) begin
                if (tx == 1'b0) begin
                    mon_active = 1;
                    mon_cnt    = 0;
                    start_cyc  = ncyc;
                    if (gap_en && have_prev) check("byte_gap", int'(start_cyc - prev_start), BYTE_GAP);
                    prev_start = start_cyc;
                    have_prev  = 1;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt >= 26 && (mon_cnt - 26) % BIT_CLKS == 0) begin
                    idx = (mon_cnt - 26) / BIT_CLKS;
                    if (idx == 0) begin
                        check("start_bit", int'(tx), 0);
                    end else if (idx <= 8) begin
                        mon_byte[idx-1] = tx;
                    end else begin
                        check("stop_bit", int'(tx), 1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_byte", int'(mon_byte), -1);
                        end else begin
                            check("byte_value", int'(mon_byte), int'(exp_q.pop_front()));
                        end
                        mon_active = 0;
                        last_stop  = ncyc;
                        bytes_since_rst++;
                        dec_count++;
                    end
                end
            end
        end
    end

    task automatic strobe_burst(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            pi_flag = 1'b1;
            pi_data = ramp ? 8'(i) : 8'($urandom_range(0, 255));
        end
        @(negedge sys_clk);
        pi_flag = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || mon_active) && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (5) @(negedge sys_clk);
        check(name, int'(n < 20000), 1);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        #5 sys_rst_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        logic [7:0] b;
        logic [9:0] frame_bits;
        int wbad;
        bit stuck;

        // 1. reset
        #190;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_full", int'(fifo_full), 0);
        check("rst_fd", int'(frame_done), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // 2. single byte 0xA5, exact waveform
        b = 8'hA5;
        frame_bits = {1'b1, b, 1'b0};
        @(negedge sys_clk);
        pi_data = b;
        pi_flag = 1'b1;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        check("latency_pre", int'(tx), 1);
        for (int k = 0; k < 10; k++) begin
            wbad = 0;
            for (int c = 0; c < BIT_CLKS; c++) begin
                @(negedge sys_clk);
                if (tx !== frame_bits[k]) wbad++;
            end
            check($sformatf("a5_bit%0d_bad_clks", k), wbad, 0);
        end
        @(negedge sys_clk);
        check("a5_busy_after", int'(busy), 0);
        check("a5_tx_after", int'(tx), 1);
        wait_idle("a5_drain");

        // 3. 16-byte ramp burst
        ff_bad = 0;
        gap_en = 1;
        have_prev = 0;
        dec_count = 0;
        strobe_burst(16, 1'b1);
        wait_idle("burst16_drain");
        gap_en = 0;
        check("burst16_count", dec_count, 16);
        check("burst16_ovf", int'(overflow), 0);
        check("burst16_full_track", ff_bad, 0);

        // 4. 18-byte random burst overflows once
        ff_bad = 0;
        seen_full = 0;
        dec_count = 0;
        strobe_burst(18, 1'b0);
        @(negedge sys_clk);
        check("burst18_ovf", int'(overflow), int'(m_ovf));
        check("burst18_ovf_set", int'(overflow), 1);
        wait_idle("burst18_drain");
        check("burst18_count", dec_count, 17);
        check("burst18_seen_full", int'(seen_full), 1);
        check("burst18_full_track", ff_bad, 0);
        check("burst18_ovf_sticky", int'(overflow), 1);

        // 5. frame_done over 8 bytes with random spacing
        do_reset();
        check("post_rst_ovf", int'(overflow), 0);
        fd_count = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            pi_data = 8'($urandom_range(0, 255));
            pi_flag = 1'b1;
            @(negedge sys_clk);
            pi_flag = 1'b0;
            repeat ($urandom_range(0, 700)) @(negedge sys_clk);
        end
        wait_idle("frame_drain");
        check("frame_done_count", fd_count, 2);

        // 6. reset in the middle of data bit 3, then a clean 0x3C
        @(negedge sys_clk);
        pi_data = 8'($urandom_range(0, 255));
        pi_flag = 1'b1;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        repeat (BIT_CLKS * 4 + 26) @(negedge sys_clk);
        #5 sys_rst_n = 1'b0;
        #1 check("abort_tx_now", int'(tx), 1);
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        stuck = 0;
        repeat (600) begin
            @(negedge sys_clk);
            if (tx !== 1'b1 || busy !== 1'b0) stuck = 1;
        end
        check("abort_quiet", int'(stuck), 0);
        dec_count = 0;
        @(negedge sys_clk);
        pi_data = 8'h3C;
        pi_flag = 1'b1;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        wait_idle("after_abort_drain");
        check("after_abort_count", dec_count, 1);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
